// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared widths and loader state encoding for the instruction
//                memory path. The processor and the ROM/RAM wrappers import
//                the same widths so the instruction word and address stay
//                consistent across the board design.
//  Contents    : c_ADDR_W  - instruction RAM address width (5)
//                c_DATA_W  - instruction word width (9, processor DIN)
//                c_DEPTH   - number of instruction RAM words (2**c_ADDR_W)
//                loader_state_t - program loader states
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_ADDR_W = 5;
    localparam int c_DATA_W = 9;
    localparam int c_DEPTH  = 2 ** c_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } loader_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect
//  Description : One-bit rising-edge detector. The input is assumed to be
//                already synchronous to clk. RESET_VAL sets the remembered
//                previous level after reset; setting it to 1 suppresses a
//                spurious edge when the input is held high through reset.
//  Ports       : clk     in  1  clock
//                rst     in  1  synchronous active-high reset
//                i_sig   in  1  level input
//                o_rise  out 1  high for the cycle in which i_sig is 1 and
//                               was 0 on the previous clock
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q <= RESET_VAL;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule : edge_detect
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_loader
//  Description : Program loader for the 32-word instruction RAM. Each rising
//                edge of the operator Load strobe writes WordIn at an
//                auto-incrementing address. Outside a session the fetch
//                address is passed straight to the RAM so one single-port RAM
//                serves both loading and execution. A running word count and
//                checksum are kept for the board displays.
//  Ports       : Clock     in  1         system clock
//                Reset     in  1         synchronous active-high reset
//                Start     in  1         begin session (from IDLE or FULL)
//                Finish    in  1         end session, back to IDLE
//                Load      in  1         operator strobe (rising edge used)
//                WordIn    in  DATA_W    word sampled on the Load edge
//                FetchAddr in  ADDR_W    fetch-counter address
//                MemAddr   out ADDR_W    RAM address
//                MemData   out DATA_W    RAM write data
//                MemWrEn   out 1         RAM write enable, one-cycle pulse
//                Loading   out 1         session active, accepting words
//                Full      out 1         all DEPTH words written
//                Count     out ADDR_W+1  words written this session
//                Checksum  out DATA_W    sum of words written, truncated
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
    import mem_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Finish,
    input  logic              Load,
    input  logic [DATA_W-1:0] WordIn,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemData,
    output logic              MemWrEn,
    output logic              Loading,
    output logic              Full,
    output logic [ADDR_W:0]   Count,
    output logic [DATA_W-1:0] Checksum
);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_checksum;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_wr_en;
    logic              r_loading;
    logic              r_full;

    logic              w_load_rise;
    logic              w_last;

    // Previous level resets to 1 so a Load held high through reset is not
    // mistaken for an operator press.
    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_load_edge (
        .clk    (Clock),
        .rst    (Reset),
        .i_sig  (Load),
        .o_rise (w_load_rise)
    );

    assign w_last = (r_wp == ADDR_W'(DEPTH - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_wp       <= '0;
            r_count    <= '0;
            r_checksum <= '0;
            r_mem_data <= '0;
            r_wr_en    <= 1'b0;
            r_loading  <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Count/Checksum stay readable in IDLE; cleared only
                    // when a new session starts.
                    if (Start) begin
                        r_state    <= ST_ARMED;
                        r_loading  <= 1'b1;
                        r_wp       <= '0;
                        r_count    <= '0;
                        r_checksum <= '0;
                    end
                end
                ST_ARMED: begin
                    // Finish wins over a same-cycle edge; that word is lost.
                    if (Finish) begin
                        r_state   <= ST_IDLE;
                        r_loading <= 1'b0;
                    end else if (w_load_rise) begin
                        r_state    <= ST_WRITE;
                        r_mem_data <= WordIn;
                        r_wr_en    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // The write always completes, even if Finish is high.
                    r_count    <= r_count + (ADDR_W + 1)'(1);
                    r_checksum <= r_checksum + r_mem_data;
                    if (!w_last) begin
                        r_wp <= r_wp + ADDR_W'(1);
                    end
                    if (Finish) begin
                        r_state   <= ST_IDLE;
                        r_loading <= 1'b0;
                    end else if (w_last) begin
                        r_state   <= ST_FULL;
                        r_loading <= 1'b0;
                        r_full    <= 1'b1;
                    end else begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_FULL: begin
                    if (Finish) begin
                        r_state <= ST_IDLE;
                        r_full  <= 1'b0;
                    end else if (Start) begin
                        r_state    <= ST_ARMED;
                        r_full     <= 1'b0;
                        r_loading  <= 1'b1;
                        r_wp       <= '0;
                        r_count    <= '0;
                        r_checksum <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_loading <= 1'b0;
                    r_full    <= 1'b0;
                end
            endcase
        end
    end

    // r_loading is high exactly in ARMED and WRITE, so it selects the write
    // pointer; otherwise the fetch counter drives the RAM combinationally.
    assign MemAddr  = r_loading ? r_wp : FetchAddr;
    assign MemData  = r_mem_data;
    assign MemWrEn  = r_wr_en;
    assign Loading  = r_loading;
    assign Full     = r_full;
    assign Count    = r_count;
    assign Checksum = r_checksum;

endmodule : mem_loader
`default_nettype wire

// File: doc/mem_loader.md
# mem_loader

Program loader that writes 9-bit instruction words into the processor's 32-word instruction RAM, one word per operator strobe, at an auto-incrementing address. It is the write side of the instruction memory; the processor reads the same RAM through the fetch counter. Outside a load session the block passes the fetch address straight through to the RAM address port, so a single-port RAM serves both loading and execution. It also reports a running word count and checksum for the board displays.

## Interface
Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 9, instruction word width (matches processor DIN)
- DEPTH, 2**ADDR_W, number of writable words

Ports:
- Clock  in  1  system clock; all state changes on its rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  level; high in IDLE or FULL begins a new session at address 0
- Finish  in  1  level; ends the session and returns to IDLE
- Load  in  1  operator strobe; the rising edge is detected internally
- WordIn  in  DATA_W  word to write, sampled on the Load edge
- FetchAddr  in  ADDR_W  fetch-counter address, used outside a session
- MemAddr  out  ADDR_W  RAM address
- MemData  out  DATA_W  RAM write data
- MemWrEn  out  1  RAM write enable, one-cycle pulse
- Loading  out  1  high in ARMED or WRITE
- Full  out  1  high in FULL
- Count  out  ADDR_W+1  words written this session, 0..DEPTH
- Checksum  out  DATA_W  sum of words written this session, mod 2**DATA_W

## Operation
- States: IDLE, ARMED, WRITE, FULL.
- Edge detect: register Load_q <= Load. Edge = Load & ~Load_q. Load_q resets to 1, so a Load held high through reset does not produce an edge.
- IDLE:
  - Start -> ARMED.
  - Clear the write pointer (wp), Count, and Checksum.
- ARMED:
  - Finish -> IDLE. Finish has priority over a same-cycle edge; that word is dropped.
  - Otherwise, an edge latches WordIn and goes to WRITE.
  - Start is ignored in this state.
- WRITE:
  - MemWrEn=1, MemAddr=wp, MemData=latched word.
  - Next cycle: wp += 1, Count += 1, Checksum += word (truncated).
  - Next state is FULL if wp was DEPTH-1, else ARMED.
  - Finish during WRITE does not abort the write. The next state is then IDLE, not ARMED or FULL.
  - Load edges seen during WRITE are discarded.
- FULL:
  - Ignores edges.
  - Finish -> IDLE.
  - Start -> ARMED, with wp, Count, and Checksum cleared.
- MemAddr:
  - wp in ARMED and WRITE.
  - FetchAddr (combinational pass-through) in IDLE and FULL.
- MemWrEn is never high outside WRITE.
- Count and Checksum hold their values in IDLE until the next Start, so they stay readable after a session ends.
- Reset values: state IDLE; wp, Count, Checksum, MemData all 0; MemWrEn 0; Loading 0; Full 0; Load_q 1.
- Reset mid-session: the next cycle is IDLE with MemWrEn 0. Words already written stay in RAM.

## Timing
- Edge at cycle k (Load=1 and Load_q=0 sampled at edge k) -> WRITE in cycle k+1 with MemWrEn=1 -> Count updated at k+2.
- Minimum spacing between accepted words is 2 cycles.
- MemWrEn, MemData, Loading, Full, Count, and Checksum are registered.
- MemAddr is registered in ARMED and WRITE, combinational from FetchAddr otherwise.
- Start or Finish seen at cycle k takes effect as a state change visible at k+1.
- Wrap: wp is ADDR_W bits and is never incremented past DEPTH-1; FULL is entered instead. Count reaches exactly DEPTH (32).

## Structure
- Shared package mem_pkg holds:
  - the ADDR_W and DATA_W defaults;
  - the loader state enum (IDLE, ARMED, WRITE, FULL);
  - the DEPTH constant.
  The processor and ROM/RAM wrappers import the same widths.
- One natural sub-module: edge_detect, a one-bit rising-edge detector with a configurable reset value. It is reusable for KEY inputs elsewhere on the board.
- The RAM itself is outside this block.

## Test plan
- Reset then Start, then Load pulses with WordIn = 9'h1C0, 9'h0A5, 9'h1FF:
  - writes land at addresses 0, 1, 2, with MemWrEn one cycle each;
  - Count=3;
  - Checksum = (0x1C0+0x0A5+0x1FF) mod 512 = 0x064.
- 32 Load pulses with WordIn = address:
  - the 32nd write lands at address 31;
  - Full=1, Count=32;
  - a 33rd pulse produces no MemWrEn;
  - MemAddr follows FetchAddr=5'd7.
- Load held high across Reset release, then Start: no write occurs until Load falls and rises again.
- Finish in the same cycle as a Load edge in ARMED: no MemWrEn, state IDLE, Count unchanged.
- Finish during WRITE: the write completes (MemWrEn=1 once), Count increments, and the next state is IDLE.
- Reset asserted in the WRITE cycle after 4 words: the next cycle is IDLE with MemWrEn=0, Count=0, and MemAddr=FetchAddr.
